// File: rtl/wb_slave_interface_pkg.sv
// Shared bus widths and FSM state type for the WISHBONE slave message receiver.
package wb_slave_interface_pkg;

  localparam int BUS_ADDRESS_WIDTH = 32;
  localparam int BUS_DATA_WIDTH    = 32;
  localparam int GRANULARITY       = 8;
  localparam int BUS_SEL_WIDTH     = BUS_DATA_WIDTH / GRANULARITY;

  typedef enum logic [1:0] {
    IDLE          = 2'd0,
    RECEIVE       = 2'd1,
    MESSAGE_READY = 2'd2
  } state_t;

endpackage

// File: rtl/wb_slave_interface_if.sv
// WISHBONE pipelined slave-side bus bundle (master drives requests, slave answers).
interface wb_slave_interface_if;
  import wb_slave_interface_pkg::*;

  logic                         CYC_I;
  logic                         STB_I;
  logic                         WE_I;
  logic [BUS_ADDRESS_WIDTH-1:0] ADR_I;
  logic [BUS_DATA_WIDTH-1:0]    DAT_I;
  logic [BUS_SEL_WIDTH-1:0]     SEL_I;
  logic                         ACK_O;
  logic                         ERR_O;
  logic                         RTY_O;
  logic                         STALL_O;

  modport slave (
    input  CYC_I, STB_I, WE_I, ADR_I, DAT_I, SEL_I,
    output ACK_O, ERR_O, RTY_O, STALL_O
  );

  modport master (
    output CYC_I, STB_I, WE_I, ADR_I, DAT_I, SEL_I,
    input  ACK_O, ERR_O, RTY_O, STALL_O
  );

endinterface

// File: rtl/wb_slave_buffer.sv
// Message beat store: one synchronous write port, one asynchronous read port.
module wb_slave_buffer #(
  parameter int DEPTH = 8,
  parameter int AW    = 3,
  parameter int WIDTH = 36
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Contents are left unreset; only entries below the stored count are ever read.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/wb_slave_interface.sv
// Collects one WISHBONE cycle (write burst or single read) into a buffered message for the NIC queue.
module wb_slave_interface
  import wb_slave_interface_pkg::*;
#(
  parameter int N_BITS_BURST_LENGHT = 7,
  parameter int MAX_BURST_LENGHT    = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  wb_slave_interface_if.slave            wb,
  output logic                           message_valid_o,
  output logic [BUS_ADDRESS_WIDTH-1:0]   address_o,
  output logic [BUS_DATA_WIDTH-1:0]      data_o,
  output logic [BUS_SEL_WIDTH-1:0]       sel_o,
  output logic                           transaction_type_o,
  output logic [N_BITS_BURST_LENGHT-1:0] burst_lenght_o,
  input  logic                           next_data_i,
  input  logic                           message_consumed_i,
  output logic                           table_insert_o
);

  localparam int NB = N_BITS_BURST_LENGHT;
  localparam int AW = (MAX_BURST_LENGHT > 1) ? $clog2(MAX_BURST_LENGHT) : 1;
  localparam int EW = BUS_DATA_WIDTH + BUS_SEL_WIDTH;
  localparam logic [NB-1:0] MAX_COUNT = NB'(MAX_BURST_LENGHT);

  state_t                       state_reg, state_next;
  logic [NB-1:0]                count_reg, count_next;
  logic [NB-1:0]                ptr_reg, ptr_next;
  logic [NB-1:0]                burst_len_reg, burst_len_next;
  logic [BUS_ADDRESS_WIDTH-1:0] address_reg, address_next;
  logic                         type_reg, type_next;
  logic                         ack_reg, ack_next;
  logic                         err_reg, err_next;
  logic                         tins_reg, tins_next;

  logic          stall;
  logic          accept;
  logic          buf_we;
  logic [AW-1:0] buf_waddr;
  logic [EW-1:0] buf_rdata;

  assign stall  = (state_reg == MESSAGE_READY);
  assign accept = wb.CYC_I & wb.STB_I & ~stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      count_reg     <= '0;
      ptr_reg       <= '0;
      burst_len_reg <= '0;
      address_reg   <= '0;
      type_reg      <= 1'b0;
      ack_reg       <= 1'b0;
      err_reg       <= 1'b0;
      tins_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      count_reg     <= count_next;
      ptr_reg       <= ptr_next;
      burst_len_reg <= burst_len_next;
      address_reg   <= address_next;
      type_reg      <= type_next;
      ack_reg       <= ack_next;
      err_reg       <= err_next;
      tins_reg      <= tins_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    count_next     = count_reg;
    ptr_next       = ptr_reg;
    burst_len_next = burst_len_reg;
    address_next   = address_reg;
    type_next      = type_reg;
    ack_next       = 1'b0;
    err_next       = 1'b0;
    tins_next      = 1'b0;
    buf_we         = 1'b0;
    buf_waddr      = count_reg[AW-1:0];

    case (state_reg)
      IDLE: begin
        if (accept) begin
          address_next = wb.ADR_I;
          type_next    = wb.WE_I;
          buf_we       = 1'b1;
          buf_waddr    = '0;
          count_next   = NB'(1);
          ack_next     = wb.WE_I;
          state_next   = RECEIVE;
        end
      end
      RECEIVE: begin
        if (!wb.CYC_I) begin
          state_next     = MESSAGE_READY;
          burst_len_next = count_reg;
          ptr_next       = '0;
          tins_next      = ~type_reg;
        end else if (accept) begin
          // Only write messages grow past one beat; reads and mismatched beats are rejected.
          if (wb.WE_I == type_reg && type_reg && count_reg < MAX_COUNT) begin
            buf_we     = 1'b1;
            count_next = count_reg + 1'b1;
            ack_next   = 1'b1;
          end else begin
            err_next = 1'b1;
          end
        end
      end
      MESSAGE_READY: begin
        if (message_consumed_i) begin
          state_next = IDLE;
          count_next = '0;
          ptr_next   = '0;
        end else if (next_data_i && ptr_reg < burst_len_reg - 1'b1) begin
          ptr_next = ptr_reg + 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  wb_slave_buffer #(
    .DEPTH (MAX_BURST_LENGHT),
    .AW    (AW),
    .WIDTH (EW)
  ) u_buffer (
    .clk   (clk),
    .we    (buf_we),
    .waddr (buf_waddr),
    .wdata ({wb.DAT_I, wb.SEL_I}),
    .raddr (ptr_reg[AW-1:0]),
    .rdata (buf_rdata)
  );

  assign wb.ACK_O   = ack_reg;
  assign wb.ERR_O   = err_reg;
  assign wb.RTY_O   = 1'b0;
  assign wb.STALL_O = stall;

  assign message_valid_o    = (state_reg == MESSAGE_READY);
  assign address_o          = address_reg;
  assign transaction_type_o = type_reg;
  assign burst_lenght_o     = burst_len_reg;
  assign table_insert_o     = tins_reg;
  assign data_o             = buf_rdata[EW-1:BUS_SEL_WIDTH];
  assign sel_o              = buf_rdata[BUS_SEL_WIDTH-1:0];

endmodule

// File: tb/tb_wb_slave_interface.sv
// Scoreboard bench: driver pushes expected beat responses/messages, monitor checks them as they appear.
module tb_wb_slave_interface;
  import wb_slave_interface_pkg::*;

  localparam int NB   = 7;
  localparam int MAXB = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wb_slave_interface_if bus();

  logic                         message_valid_o;
  logic [BUS_ADDRESS_WIDTH-1:0] address_o;
  logic [BUS_DATA_WIDTH-1:0]    data_o;
  logic [BUS_SEL_WIDTH-1:0]     sel_o;
  logic                         transaction_type_o;
  logic [NB-1:0]                burst_lenght_o;
  logic                         next_data_i = 1'b0;
  logic                         message_consumed_i = 1'b0;
  logic                         table_insert_o;

  wb_slave_interface #(
    .N_BITS_BURST_LENGHT (NB),
    .MAX_BURST_LENGHT    (MAXB)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .wb                 (bus),
    .message_valid_o    (message_valid_o),
    .address_o          (address_o),
    .data_o             (data_o),
    .sel_o              (sel_o),
    .transaction_type_o (transaction_type_o),
    .burst_lenght_o     (burst_lenght_o),
    .next_data_i        (next_data_i),
    .message_consumed_i (message_consumed_i),
    .table_insert_o     (table_insert_o)
  );

  int tests = 0;
  int fails = 0;
  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  typedef struct { bit is_err; int cycle; } resp_t;
  typedef struct { logic [BUS_ADDRESS_WIDTH-1:0] adr; bit typ; int len; int cycle; } msg_t;
  resp_t resp_q[$];
  msg_t  msg_q[$];

  // Stimulus beats and the expected outcome computed from the message rules.
  logic                         b_we  [16];
  logic [BUS_ADDRESS_WIDTH-1:0] b_adr [16];
  logic [BUS_DATA_WIDTH-1:0]    b_dat [16];
  logic [BUS_SEL_WIDTH-1:0]     b_sel [16];
  int                           exp_resp [16];
  logic [BUS_ADDRESS_WIDTH-1:0] exp_adr;
  bit                           exp_type;
  int                           exp_len;
  logic [BUS_DATA_WIDTH-1:0]    exp_dat[$];
  logic [BUS_SEL_WIDTH-1:0]     exp_sel[$];
  int                           last_stall_wait;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc_cnt);
    end
  endtask

  // Reference: first beat opens the message; only same-type write beats below the depth are kept.
  task automatic build_model(input int n);
    int count;
    exp_type = b_we[0];
    exp_adr  = b_adr[0];
    exp_dat.delete();
    exp_sel.delete();
    exp_dat.push_back(b_dat[0]);
    exp_sel.push_back(b_sel[0]);
    exp_resp[0] = b_we[0] ? 1 : 0;
    count = 1;
    for (int i = 1; i < n; i++) begin
      if (b_we[i] == exp_type && exp_type && count < MAXB) begin
        exp_dat.push_back(b_dat[i]);
        exp_sel.push_back(b_sel[i]);
        count++;
        exp_resp[i] = 1;
      end else begin
        exp_resp[i] = 2;
      end
    end
    exp_len = count;
  endtask

  task automatic set_beat(input int i, input logic we, input logic [31:0] adr, input logic [31:0] dat);
    b_we[i]  = we;
    b_adr[i] = adr;
    b_dat[i] = dat;
    b_sel[i] = BUS_SEL_WIDTH'($urandom_range(0, 15));
  endtask

  task automatic drive_beats(input int n, input bit close, input bit gaps);
    for (int i = 0; i < n; i++) begin
      int w;
      bus.CYC_I = 1'b1;
      bus.STB_I = 1'b1;
      bus.WE_I  = b_we[i];
      bus.ADR_I = b_adr[i];
      bus.DAT_I = b_dat[i];
      bus.SEL_I = b_sel[i];
      w = 0;
      while (bus.STALL_O === 1'b1 && w < 50) begin
        @(negedge clk); #2;
        w++;
      end
      last_stall_wait = w;
      if (w >= 50) check("stall_timeout", 64'(w), 64'(0));
      if (exp_resp[i] != 0) resp_q.push_back('{exp_resp[i] == 2, cyc_cnt + 1});
      @(negedge clk); #2;
      if (gaps && ($urandom % 4 == 0)) begin
        bus.STB_I = 1'b0;
        @(negedge clk); #2;
      end
    end
    bus.STB_I = 1'b0;
    if (close) begin
      bus.CYC_I = 1'b0;
      msg_q.push_back('{exp_adr, exp_type, exp_len, cyc_cnt + 1});
    end
  endtask

  task automatic read_message();
    int w;
    w = 0;
    while (message_valid_o !== 1'b1 && w < 20) begin
      @(negedge clk); #2;
      w++;
    end
    if (w >= 20) begin
      check("message_valid_timeout", 64'(message_valid_o), 64'(1));
      return;
    end
    for (int i = 0; i < exp_len; i++) begin
      check($sformatf("data_o[%0d]", i), 64'(data_o), 64'(exp_dat[i]));
      check($sformatf("sel_o[%0d]", i), 64'(sel_o), 64'(exp_sel[i]));
      next_data_i = 1'b1;
      @(negedge clk); #2;
      next_data_i = 1'b0;
    end
    check("data_o_saturated", 64'(data_o), 64'(exp_dat[exp_len-1]));
  endtask

  task automatic consume();
    message_consumed_i = 1'b1;
    @(negedge clk); #2;
    message_consumed_i = 1'b0;
    check("valid_after_consume", 64'(message_valid_o), 64'(0));
    check("stall_after_consume", 64'(bus.STALL_O), 64'(0));
  endtask

  task automatic run_message(input int n, input bit gaps);
    build_model(n);
    drive_beats(n, 1'b1, gaps);
    read_message();
    consume();
  endtask

  // Monitor: responses and message headers compared whenever the DUT presents them.
  bit    valid_prev = 1'b0;
  resp_t mon_r;
  msg_t  mon_m;
  always @(negedge clk) begin
    if (bus.ACK_O === 1'b1 || bus.ERR_O === 1'b1) begin
      if (resp_q.size() == 0) begin
        check("unexpected_ack_err", 64'({bus.ACK_O, bus.ERR_O}), 64'(0));
      end else begin
        mon_r = resp_q.pop_front();
        check("resp_ack_err", 64'({bus.ACK_O, bus.ERR_O}), mon_r.is_err ? 64'(1) : 64'(2));
        check("resp_cycle", 64'(cyc_cnt), 64'(mon_r.cycle));
      end
    end
    if (message_valid_o === 1'b1 && !valid_prev) begin
      if (msg_q.size() == 0) begin
        check("unexpected_message", 64'(message_valid_o), 64'(0));
      end else begin
        mon_m = msg_q.pop_front();
        check("msg_cycle", 64'(cyc_cnt), 64'(mon_m.cycle));
        check("address_o", 64'(address_o), 64'(mon_m.adr));
        check("transaction_type_o", 64'(transaction_type_o), 64'(mon_m.typ));
        check("burst_lenght_o", 64'(burst_lenght_o), 64'(mon_m.len));
        check("table_insert_pulse", 64'(table_insert_o), 64'(!mon_m.typ));
        check("stall_in_ready", 64'(bus.STALL_O), 64'(1));
      end
    end else if (message_valid_o === 1'b1) begin
      check("table_insert_once", 64'(table_insert_o), 64'(0));
    end else if (table_insert_o !== 1'b0) begin
      check("table_insert_idle", 64'(table_insert_o), 64'(0));
    end
    valid_prev = (message_valid_o === 1'b1);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc_cnt);
    $fatal(1);
  end

  initial begin
    bus.CYC_I = 1'b0; bus.STB_I = 1'b0; bus.WE_I = 1'b0;
    bus.ADR_I = '0;   bus.DAT_I = '0;   bus.SEL_I = '0;
    repeat (2) @(negedge clk);
    #2;
    check("rst_ack", 64'(bus.ACK_O), 64'(0));
    check("rst_err", 64'(bus.ERR_O), 64'(0));
    check("rst_rty", 64'(bus.RTY_O), 64'(0));
    check("rst_stall", 64'(bus.STALL_O), 64'(0));
    check("rst_valid", 64'(message_valid_o), 64'(0));
    check("rst_tins", 64'(table_insert_o), 64'(0));
    check("rst_addr", 64'(address_o), 64'(0));
    check("rst_len", 64'(burst_lenght_o), 64'(0));
    rst = 1'b0;
    @(negedge clk); #2;

    // 4-beat write burst
    for (int i = 0; i < 4; i++) set_beat(i, 1'b1, 32'h100 + 32'(i), $urandom);
    run_message(4, 1'b0);

    // single read at 0x1234
    set_beat(0, 1'b0, 32'h1234, $urandom);
    run_message(1, 1'b0);

    // 9-beat write overflowing the 8-entry buffer
    for (int i = 0; i < 9; i++) set_beat(i, 1'b1, 32'h2000 + 32'(i), $urandom);
    run_message(9, 1'b0);

    // write then read in one cycle
    set_beat(0, 1'b1, 32'h3000, $urandom);
    set_beat(1, 1'b0, 32'h3004, $urandom);
    run_message(2, 1'b0);

    // new cycle arrives while a message is pending
    for (int i = 0; i < 2; i++) set_beat(i, 1'b1, 32'h4000 + 32'(i), $urandom);
    build_model(2);
    drive_beats(2, 1'b1, 1'b0);
    read_message();
    for (int i = 0; i < 3; i++) set_beat(i, 1'b1, 32'h5000 + 32'(i), $urandom);
    build_model(3);
    fork
      begin
        repeat (3) @(negedge clk);
        #2;
        message_consumed_i = 1'b1;
        @(negedge clk); #2;
        message_consumed_i = 1'b0;
      end
      drive_beats(3, 1'b1, 1'b0);
    join
    read_message();
    consume();

    // reset mid-burst after two beats
    for (int i = 0; i < 4; i++) set_beat(i, 1'b1, 32'h6000 + 32'(i), $urandom);
    build_model(2);
    drive_beats(2, 1'b0, 1'b0);
    bus.STB_I = 1'b1;
    rst = 1'b1;
    #1;
    check("midrst_ack", 64'(bus.ACK_O), 64'(0));
    check("midrst_valid", 64'(message_valid_o), 64'(0));
    check("midrst_addr", 64'(address_o), 64'(0));
    check("midrst_type", 64'(transaction_type_o), 64'(0));
    check("midrst_len", 64'(burst_lenght_o), 64'(0));
    @(negedge clk); #2;
    rst = 1'b0;
    bus.CYC_I = 1'b0;
    bus.STB_I = 1'b0;
    @(negedge clk); #2;
    check("midrst_pending_resp", 64'(resp_q.size()), 64'(0));
    set_beat(0, 1'b1, 32'h7000, $urandom);
    run_message(1, 1'b0);

    // randomized messages
    for (int m = 0; m < 12; m++) begin
      int n;
      bit t;
      n = $urandom_range(1, 10);
      t = 1'($urandom % 2);
      for (int i = 0; i < n; i++) begin
        set_beat(i, ($urandom % 5 == 0) ? ~t : t, $urandom, $urandom);
      end
      run_message(n, 1'b1);
    end

    repeat (3) @(negedge clk);
    #2;
    check("resp_queue_drained", 64'(resp_q.size()), 64'(0));
    check("msg_queue_drained", 64'(msg_q.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/wb_slave_interface.md
WB_SLAVE_INTERFACE -- requirements
Module: wb_slave_interface

Interface
REQ-001 Parameter N_BITS_BURST_LENGHT, default 7, width of beat counters and burst_lenght_o.
REQ-002 Parameter MAX_BURST_LENGHT, default 8, message buffer depth in beats; SHALL be at most 2^N_BITS_BURST_LENGHT-1.
REQ-003 Ports, in order:
- clk  in  1  clock.
- rst  in  1  reset.
- CYC_I  in  1  WISHBONE cycle.
- STB_I  in  1  strobe, already address-decoded to this node.
- WE_I  in  1  write enable.
- ADR_I  in  BUS_ADDRESS_WIDTH  address.
- DAT_I  in  BUS_DATA_WIDTH  write data.
- SEL_I  in  BUS_DATA_WIDTH/GRANULARITY  byte select.
- ACK_O  out  1  beat acknowledge, writes only.
- ERR_O  out  1  beat error.
- RTY_O  out  1  retry; tied 0.
- STALL_O  out  1  pipeline stall.
- message_valid_o  out  1  buffered message ready for the queue.
- address_o  out  BUS_ADDRESS_WIDTH  address of first beat.
- data_o  out  BUS_DATA_WIDTH  buffer entry at read pointer.
- sel_o  out  BUS_DATA_WIDTH/GRANULARITY  SEL of entry at read pointer.
- transaction_type_o  out  1  WE of message.
- burst_lenght_o  out  N_BITS_BURST_LENGHT  beats stored.
- next_data_i  in  1  advance read pointer.
- message_consumed_i  in  1  queue took whole message; free buffer.
- table_insert_o  out  1  one-cycle pulse: register read in on-the-fly table.
REQ-004 One clock, clk; reset rst is asynchronous and active-high.

Function
REQ-005 States: IDLE, RECEIVE, MESSAGE_READY.
REQ-006 A beat is accepted when CYC_I & STB_I & !STALL_O.
REQ-007 IDLE: accepted beat stores ADR_I into address_o, WE_I into transaction_type_o, DAT_I/SEL_I into entry 0; count becomes 1; next state RECEIVE.
REQ-008 RECEIVE: each accepted beat with WE_I equal to the stored type and count<MAX_BURST_LENGHT is written to entry[count], count+1.
REQ-009 ACK_O is registered: high exactly one cycle after each accepted stored write beat; never generated for reads (read ACK comes from wb_master_interface).
REQ-010 Read messages store one beat only; further read beats in the same cycle are errors.
REQ-011 ERR_O is registered, high one cycle after an accepted beat that is discarded: type mismatch, count already MAX_BURST_LENGHT, or second read beat; discarded beats do not change count.
REQ-012 CYC_I low in RECEIVE -> MESSAGE_READY next cycle; message_valid_o=1, burst_lenght_o=count, read pointer 0.
REQ-013 Entering MESSAGE_READY with transaction_type_o=0: table_insert_o pulses for exactly one cycle.
REQ-014 STALL_O = (state==MESSAGE_READY); combinational from state; master holds the beat until buffer is freed.
REQ-015 MESSAGE_READY: next_data_i increments read pointer (saturates at burst_lenght_o-1); data_o/sel_o combinational from entry[pointer].
REQ-016 message_consumed_i in MESSAGE_READY -> IDLE next cycle, count and pointer 0, message_valid_o 0; ignored in other states.
REQ-017 Simultaneous message_consumed_i and stalled STB_I: beat not accepted that cycle; accepted earliest next cycle in IDLE.
REQ-018 CYC_I drop in IDLE or MESSAGE_READY has no effect; STB_I without CYC_I is ignored.

Reset
REQ-019 rst asserted (any time, incl. mid-burst): state IDLE, count 0, pointer 0, ACK_O/ERR_O/message_valid_o/table_insert_o 0, address_o/transaction_type_o/burst_lenght_o 0; buffer contents need not reset.
REQ-020 No beat accepted or acknowledged while rst is high.

Structure
REQ-021 BUS_ADDRESS_WIDTH, BUS_DATA_WIDTH, GRANULARITY come from NIC-defines.v; state encodings are local.
REQ-022 One sub-module natural: wb_slave_buffer (MAX_BURST_LENGHT x {DAT,SEL} register file, one write port, one async read port).

Verification
REQ-023 Write burst 4 beats no gaps -> ACK_O high 4 consecutive cycles one cycle late; after CYC_I drop message_valid_o=1, burst_lenght_o=4, data_o entries in order.
REQ-024 Single read, ADR 0x1234 -> no ACK_O, table_insert_o one pulse, transaction_type_o=0, burst_lenght_o=1.
REQ-025 Write burst 9 beats, MAX 8 -> 8 ACKs then ERR_O on beat 9; burst_lenght_o=8.
REQ-026 New cycle while MESSAGE_READY -> STALL_O=1 until message_consumed_i; beat accepted cycle after IDLE; ACK one cycle later.
REQ-027 rst pulse mid-burst after 2 beats -> outputs zero immediately; following 1-beat write yields burst_lenght_o=1.
REQ-028 Write then read beat in one cycle -> ERR_O on read beat; message type write, length 1.
